bus_arbiter: RTL and testbench
==============================

// Module: bus_arbiter
// PURPOSE
//  Shared-bus arbiter and memory/GPIO front end sitting directly downstream of the
//  core(s). Accepts grant_request/rw/address/data_out from up to NUM_MASTERS cores,
//  picks one round-robin and performs a single byte access.
//  Targets are the external synchronous RAM (addr[8]=0) or the internal GPIO
//  registers (addr[8]=1). Returns read data with a one-cycle grant_given pulse.
// PARAMETERS
//  NUM_MASTERS  2  number of requesting cores (1..4)
//  MEM_LATENCY  1  cycles from mem_en to valid mem_rdata (1..7)
// PORTS
//  clk        in   1              clock; all logic on posedge clk
//  reset      in   1              synchronous, active-high
//  req        in   NUM_MASTERS    grant_request per master
//  rw         in   NUM_MASTERS    per master: 1 = write, 0 = read
//  addr       in   9*NUM_MASTERS  per master: bit8 = GPIO select, [7:0] = byte address
//  wdata      in   8*NUM_MASTERS  per master write data (core data_out)
//  grant      out  NUM_MASTERS    grant_given per master, one-hot, 1-cycle pulse
//  rdata      out  8              read data, broadcast to all masters, valid while grant!=0
//  mem_en     out  1              RAM access strobe, 1 cycle per RAM access
//  mem_we     out  1              RAM write enable, qualified by mem_en
//  mem_addr   out  8              RAM address
//  mem_wdata  out  8              RAM write data
//  mem_rdata  in   8              RAM read data, valid MEM_LATENCY cycles after mem_en
//  gpio_in    in   8              external input pins, sampled on read
//  gpio_out   out  8              output latch register
// BEHAVIOUR
//  Reset: state=IDLE, rr pointer=0.
//   All outputs 0: grant, rdata, mem_en, mem_we, mem_addr, mem_wdata, gpio_out.
//   Reset mid-access aborts the access; no grant is issued for it.
//  FSM states: IDLE -> ACCESS -> [WAIT] -> GRANT -> RELEASE -> IDLE.
//  IDLE: if any req, select master sel by round-robin starting at pointer.
//   Register sel, rw, addr, wdata; go to ACCESS. Otherwise stay.
//  ACCESS, RAM target: mem_en=1, mem_we=rw, mem_addr/mem_wdata from latched values.
//   Read: load counter=MEM_LATENCY-1, go to WAIT.
//   Write: go to GRANT with rdata=0.
//  ACCESS, GPIO target:
//   Write to addr[7:0]=0x00 loads gpio_out; writes to other addresses are dropped.
//   Read of 0x00 returns gpio_out; read of 0x01 returns gpio_in.
//   Reads of other addresses return 0.
//   Go to GRANT.
//  WAIT: when counter==0, capture mem_rdata into rdata and go to GRANT;
//   otherwise decrement.
//  GRANT: grant[sel]=1 for exactly one cycle, rdata held. Pointer <= sel+1 mod NUM_MASTERS.
//  RELEASE: one cycle with grant=0, during which all req are ignored.
//   Covers the core dropping grant_request one cycle after it sees grant_given.
//   Then return to IDLE.
//  Latency, req seen in IDLE to grant:
//   RAM read = 2+MEM_LATENCY cycles; RAM write = 2; GPIO = 2.
//  rdata keeps its value until the next GRANT or reset.
//  Request inputs are sampled only in IDLE. Changes in other states are ignored.
//  Simultaneous requests: lowest index at or after pointer wins.
//   Losers keep req high and are served later; no starvation.
//  Bus throughput: at most one access per 4+ cycles. grant is never multi-hot.
// STRUCTURE
//  Shared package bus_pkg:
//   ADDR_W=9, DATA_W=8, GPIO_SEL_BIT=8,
//   GPIO_OUT_ADDR=8'h00, GPIO_IN_ADDR=8'h01,
//   typedef enum bus_state_t {IDLE,ACCESS,WAIT,GRANT,RELEASE}.
//  Sub-module rr_arbiter: combinational req+pointer -> one-hot pick + index.
//  Everything else lives in this module.
// TESTING
//  1. Reset, then master0 reads RAM 0x10 (RAM model holds 0xA5).
//     -> mem_en at cycle+1; grant[0] at cycle+3 with rdata=0xA5.
//  2. Master0 writes 0x3C to 0x05.
//     -> mem_en=mem_we=1, mem_addr=0x05; grant[0] 2 cycles after req; rdata=0x00.
//  3. Master1 writes 0x5A to 0x100, then reads 0x100.
//     -> gpio_out=0x5A, read rdata=0x5A. Read of 0x101 with gpio_in=0xC3 -> rdata=0xC3.
//  4. req=2'b11 held continuously from reset.
//     -> grants alternate 0,1,0,1; never both; one RELEASE cycle between grants.
//  5. Master0 req held one cycle past grant as the core does.
//     -> exactly one access and one grant pulse per request.
//  6. Reset asserted while in WAIT.
//     -> next cycle: IDLE, grant=0, mem_en=0, gpio_out=0, no late grant appears.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and constants for the bus arbiter / memory-GPIO front end.
package bus_pkg;

  localparam int unsigned ADDR_W       = 9;
  localparam int unsigned DATA_W       = 8;
  localparam int unsigned GPIO_SEL_BIT = 8;

  localparam logic [7:0] GPIO_OUT_ADDR = 8'h00;
  localparam logic [7:0] GPIO_IN_ADDR  = 8'h01;

  typedef enum logic [2:0] {
    StIdle,
    StAccess,
    StWait,
    StGrant,
    StRelease
  } bus_state_t;

  // Master index width; never zero so single-master builds still elaborate.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after the pointer wins.
module rr_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2
) (
  input  logic [NUM_MASTERS-1:0]           req_i,
  input  logic [idx_width(NUM_MASTERS)-1:0] ptr_i,
  output logic                              valid_o,
  output logic [NUM_MASTERS-1:0]            gnt_o,
  output logic [idx_width(NUM_MASTERS)-1:0] idx_o
);

  localparam int unsigned IdxW = idx_width(NUM_MASTERS);

  always_comb begin
    int unsigned cand;
    cand    = 0;
    valid_o = 1'b0;
    gnt_o   = '0;
    idx_o   = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      cand = (32'(ptr_i) + i) % NUM_MASTERS;
      if (!valid_o && req_i[cand]) begin
        valid_o     = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand[IdxW-1:0];
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Shared-bus arbiter: round-robin master select, one byte access to RAM or GPIO,
// read data returned alongside a single-cycle grant pulse.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_MASTERS-1:0]        req_i,
  input  logic [NUM_MASTERS-1:0]        rw_i,
  input  logic [ADDR_W*NUM_MASTERS-1:0] addr_i,
  input  logic [DATA_W*NUM_MASTERS-1:0] wdata_i,
  output logic [NUM_MASTERS-1:0]        grant_o,
  output logic [DATA_W-1:0]             rdata_o,
  output logic                          mem_en_o,
  output logic                          mem_we_o,
  output logic [7:0]                    mem_addr_o,
  output logic [DATA_W-1:0]             mem_wdata_o,
  input  logic [DATA_W-1:0]             mem_rdata_i,
  input  logic [7:0]                    gpio_in_i,
  output logic [7:0]                    gpio_out_o
);

  localparam int unsigned IdxW = idx_width(NUM_MASTERS);

  bus_state_t                state_q, state_d;
  logic [IdxW-1:0]           ptr_q, ptr_d, sel_q, sel_d;
  logic [NUM_MASTERS-1:0]    gnt_q, gnt_d;
  logic                      rw_q, rw_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic [DATA_W-1:0]         wdata_q, wdata_d, rdata_q, rdata_d, gpio_q, gpio_d;
  logic [2:0]                cnt_q, cnt_d;

  logic                      pick_valid;
  logic [NUM_MASTERS-1:0]    pick_gnt;
  logic [IdxW-1:0]           pick_idx;
  logic                      is_gpio;

  rr_arbiter #(
    .NUM_MASTERS(NUM_MASTERS)
  ) u_rr (
    .req_i  (req_i),
    .ptr_i  (ptr_q),
    .valid_o(pick_valid),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx)
  );

  assign is_gpio = addr_q[GPIO_SEL_BIT];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    gpio_d  = gpio_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          sel_d   = pick_idx;
          gnt_d   = pick_gnt;
          rw_d    = rw_i[pick_idx];
          addr_d  = addr_i[32'(pick_idx)*ADDR_W +: ADDR_W];
          wdata_d = wdata_i[32'(pick_idx)*DATA_W +: DATA_W];
          state_d = StAccess;
        end
      end
      StAccess: begin
        if (!is_gpio && !rw_q) begin
          cnt_d   = 3'(MEM_LATENCY - 1);
          state_d = StWait;
        end else begin
          state_d = StGrant;
          if (rw_q) begin
            rdata_d = '0;
            if (is_gpio && addr_q[7:0] == GPIO_OUT_ADDR) gpio_d = wdata_q;
          end else if (addr_q[7:0] == GPIO_OUT_ADDR) begin
            rdata_d = gpio_q;
          end else if (addr_q[7:0] == GPIO_IN_ADDR) begin
            rdata_d = gpio_in_i;
          end else begin
            rdata_d = '0;
          end
        end
      end
      StWait: begin
        if (cnt_q == 3'd0) begin
          rdata_d = mem_rdata_i;
          state_d = StGrant;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      StGrant: begin
        ptr_d   = (32'(sel_q) == NUM_MASTERS - 1) ? '0 : sel_q + 1'b1;
        state_d = StRelease;
      end
      // Absorbs the core's late req drop after it has seen its grant.
      StRelease: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      gpio_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      gpio_q  <= gpio_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant_o     = (state_q == StGrant) ? gnt_q : '0;
  assign rdata_o     = rdata_q;
  assign mem_en_o    = (state_q == StAccess) && !is_gpio;
  assign mem_we_o    = mem_en_o && rw_q;
  assign mem_addr_o  = addr_q[7:0];
  assign mem_wdata_o = wdata_q;
  assign gpio_out_o  = gpio_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed transactions plus a transaction-timing model checked every cycle.
module tb_bus_arbiter;

  localparam int NM = 2;
  localparam int ML = 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [NM-1:0] req_i;
  logic [NM-1:0] rw_i;
  logic [9*NM-1:0] addr_i;
  logic [8*NM-1:0] wdata_i;
  logic [NM-1:0] grant_o;
  logic [7:0]    rdata_o;
  logic          mem_en_o, mem_we_o;
  logic [7:0]    mem_addr_o, mem_wdata_o, mem_rdata_i, gpio_in_i, gpio_out_o;

  bus_arbiter #(
    .NUM_MASTERS(NM),
    .MEM_LATENCY(ML)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_i      (req_i),
    .rw_i       (rw_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .grant_o    (grant_o),
    .rdata_o    (rdata_o),
    .mem_en_o   (mem_en_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i),
    .gpio_in_i  (gpio_in_i),
    .gpio_out_o (gpio_out_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_grants = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Synchronous RAM with one cycle read latency
  logic [7:0] ram [256];
  always @(posedge clk) begin
    if (mem_en_o) begin
      if (mem_we_o) ram[mem_addr_o] <= mem_wdata_o;
      else          mem_rdata_i     <= ram[mem_addr_o];
    end
  end

  // Transaction-level model: on a sampled request, schedule when each effect must appear
  int         cyc = 0, t_start, t_grant, t_free, sel, m_ptr, lat;
  bit         busy = 0, chk_en = 0, gpio_pend = 0, found;
  logic       tw;
  logic [8:0] ta;
  logic [7:0] td, res, m_gpio, m_rdata, gpio_val;
  logic [7:0] m_mem [256];
  logic [NM-1:0] exp_grant;
  logic       exp_mem_en, exp_mem_we;
  logic [7:0] exp_mem_addr, exp_mem_wdata, exp_rdata, exp_gpio;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      chk_en = 1; busy = 0; gpio_pend = 0; m_ptr = 0; m_gpio = 0; m_rdata = 0;
    end else begin
      if (busy && cyc >= t_free) busy = 0;
      if (gpio_pend && cyc == t_start + 1) begin m_gpio = gpio_val; gpio_pend = 0; end
      if (busy && cyc == t_grant) begin m_rdata = res; m_ptr = (sel + 1) % NM; end
      if (!busy && req_i != '0) begin
        found = 0;
        for (int i = 0; i < NM; i++) begin
          if (!found && req_i[(m_ptr + i) % NM]) begin found = 1; sel = (m_ptr + i) % NM; end
        end
        tw = rw_i[sel]; ta = addr_i[sel*9 +: 9]; td = wdata_i[sel*8 +: 8];
        lat = 2;
        if (ta[8]) begin
          if (tw) begin
            res = 8'h00;
            if (ta[7:0] == 8'h00) begin gpio_pend = 1; gpio_val = td; end
          end else begin
            res = (ta[7:0] == 8'h00) ? m_gpio : (ta[7:0] == 8'h01) ? gpio_in_i : 8'h00;
          end
        end else if (tw) begin
          m_mem[ta[7:0]] = td; res = 8'h00;
        end else begin
          res = m_mem[ta[7:0]]; lat = 2 + ML;
        end
        busy = 1; t_start = cyc; t_grant = cyc - 1 + lat; t_free = cyc + lat + 2;
      end
    end
    exp_grant     = (busy && cyc == t_grant) ? NM'(1 << sel) : '0;
    exp_mem_en    = busy && cyc == t_start && !ta[8];
    exp_mem_we    = tw;
    exp_mem_addr  = ta[7:0];
    exp_mem_wdata = td;
    exp_rdata     = m_rdata;
    exp_gpio      = m_gpio;
  end

  always @(negedge clk) begin
    if (grant_o != '0) n_grants++;
    if (chk_en) begin
      check("model_grant", grant_o, exp_grant);
      check("model_mem_en", mem_en_o, exp_mem_en);
      check("model_rdata", rdata_o, exp_rdata);
      check("model_gpio_out", gpio_out_o, exp_gpio);
      if (exp_mem_en) begin
        check("model_mem_we", mem_we_o, exp_mem_we);
        check("model_mem_addr", mem_addr_o, exp_mem_addr);
        check("model_mem_wdata", mem_wdata_o, exp_mem_wdata);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_master(input int m, input logic w, input logic [8:0] a, input logic [7:0] d);
    rw_i[m]          = w;
    addr_i[m*9 +: 9] = a;
    wdata_i[m*8 +: 8] = d;
  endtask

  // Core-like handshake: hold req until one cycle after the grant pulse.
  task automatic run_txn(input int m, input logic w, input logic [8:0] a, input logic [7:0] d,
                         input int exp_lat, input logic [7:0] exp_rd);
    int n;
    set_master(m, w, a, d);
    req_i[m] = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
      if (n == 1) begin
        check("access_mem_en", mem_en_o, !a[8]);
        if (!a[8]) begin
          check("access_mem_we", mem_we_o, w);
          check("access_mem_addr", mem_addr_o, a[7:0]);
        end
      end
    end while (grant_o == '0 && n < 20);
    check("grant_latency", n, exp_lat);
    check("grant_onehot", grant_o, 1 << m);
    check("grant_rdata", rdata_o, exp_rd);
    tick();
    check("release_gap", grant_o, 0);
    tick();
    req_i[m] = 1'b0;
    tick();
    tick();
  endtask

  logic [NM-1:0] got [4];
  int gc [4];
  int ng, n, g0;

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i] = 8'(i * 7 + 3);
      m_mem[i] = 8'(i * 7 + 3);
    end
    ram[8'h10] = 8'hA5; m_mem[8'h10] = 8'hA5;
    reset = 1'b1; req_i = '0; rw_i = '0; addr_i = '0; wdata_i = '0; gpio_in_i = 8'h00;
    tick(); tick();
    check("reset_grant", grant_o, 0);
    check("reset_rdata", rdata_o, 0);
    check("reset_mem_en", mem_en_o, 0);
    check("reset_mem_addr", mem_addr_o, 0);
    check("reset_gpio_out", gpio_out_o, 0);
    reset = 1'b0;
    tick();

    run_txn(0, 1'b0, 9'h010, 8'h00, 3, 8'hA5);
    run_txn(0, 1'b1, 9'h005, 8'h3C, 2, 8'h00);
    run_txn(1, 1'b0, 9'h005, 8'h00, 3, 8'h3C);

    run_txn(1, 1'b1, 9'h100, 8'h5A, 2, 8'h00);
    check("gpio_out_loaded", gpio_out_o, 8'h5A);
    run_txn(1, 1'b0, 9'h100, 8'h00, 2, 8'h5A);
    gpio_in_i = 8'hC3;
    run_txn(1, 1'b0, 9'h101, 8'h00, 2, 8'hC3);
    run_txn(0, 1'b0, 9'h1FF, 8'h00, 2, 8'h00);
    run_txn(0, 1'b1, 9'h105, 8'h77, 2, 8'h00);
    check("gpio_write_dropped", gpio_out_o, 8'h5A);

    g0 = n_grants;
    run_txn(0, 1'b0, 9'h033, 8'h00, 3, 8'(8'h33 * 7 + 3));
    check("one_grant_per_req", n_grants - g0, 1);

    // Reset while waiting on RAM read data
    set_master(0, 1'b0, 9'h010, 8'h00);
    req_i = 2'b01;
    tick(); tick();
    reset = 1'b1; req_i = '0;
    tick();
    check("abort_grant", grant_o, 0);
    check("abort_mem_en", mem_en_o, 0);
    check("abort_gpio_out", gpio_out_o, 0);
    check("abort_rdata", rdata_o, 0);
    reset = 1'b0;
    g0 = n_grants;
    repeat (6) tick();
    check("abort_no_late_grant", n_grants - g0, 0);

    // Both masters requesting continuously from reset
    reset = 1'b1;
    set_master(0, 1'b0, 9'h020, 8'h00);
    set_master(1, 1'b0, 9'h021, 8'h00);
    req_i = 2'b11;
    tick(); tick();
    reset = 1'b0;
    ng = 0; n = 0;
    for (int i = 0; i < 4; i++) begin got[i] = '0; gc[i] = 0; end
    while (ng < 4 && n < 60) begin
      tick();
      n++;
      if (grant_o != '0) begin got[ng] = grant_o; gc[ng] = n; ng++; end
    end
    check("rr_count", ng, 4);
    for (int i = 0; i < 4; i++) check("rr_order", got[i], (i % 2 == 0) ? 1 : 2);
    for (int i = 1; i < 4; i++) check("rr_spacing", gc[i] - gc[i-1], 2 + ML + 2);
    req_i = '0;
    repeat (8) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
